seq_divider_32by16: RTL and testbench

- Sequential restoring divider; the inverse of the team's 16x16 Wallace multiplier.
- Takes a 2W-bit product-width dividend Z and a W-bit divisor B.
- Returns W-bit quotient A and W-bit remainder R such that Z = A*B + R.
- One quotient bit per clock. Valid/ready handshakes on both input and output, so it drops into the datapath beside the multiplier.

---
 rtl/seq_divider_32by16.sv | 184 ++++++++++++++++++
 tb/tb_seq_divider_32by16.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32by16.sv
// seq_divider_32by16: sequential restoring divider, one quotient bit per clock.
//
// Divides a 2*WIDTH-bit dividend Z by a WIDTH-bit divisor B, giving quotient A
// and remainder R with Z = A*B + R. Divide-by-zero and quotient overflow are
// detected at accept time and reported one cycle later without iterating.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   Z/B presented          in_ready   block idle, can accept
//   Z          dividend (2*WIDTH)     B          divisor (WIDTH)
//   out_valid  result valid           out_ready  consumer accepts result
//   A          quotient               R          remainder
//   div_zero   B was zero             ovf        quotient does not fit in WIDTH bits
module seq_divider_32by16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   Z,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     R,
    output logic                 div_zero,
    output logic                 ovf
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    // Partial remainder is always < B after a restoring step, so its extra
    // (WIDTH+1)th bit is always zero and is not stored; it is recreated in
    // the shifted trial value below.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] z_hi;
    logic             is_zero;
    logic             too_big;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] qsh_next;

    assign z_hi      = Z[2*WIDTH-1:WIDTH];
    assign is_zero   = (B == '0);
    assign too_big   = (z_hi >= B);
    assign last_iter = (cnt_q == CNT_W'(1));

    // One restoring step: shift in the next dividend bit, try subtracting B;
    // the borrow (MSB of the WIDTH+1 bit difference) decides the quotient bit.
    assign shifted  = {rem_q, qsh_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, b_q};
    assign qbit     = ~trial[WIDTH];
    assign rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign qsh_next = {qsh_q[WIDTH-2:0], qbit};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (is_zero || too_big) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: state-only, no combinational path from in_valid/out_ready
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath next-state
    always_comb begin
        rem_d = rem_q;
        qsh_d = qsh_q;
        b_d   = b_q;
        a_d   = a_q;
        r_d   = r_q;
        dz_d  = dz_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    b_d = B;
                    if (is_zero) begin
                        dz_d  = 1'b1;
                        ovf_d = 1'b0;
                        a_d   = '1;
                        r_d   = '0;
                    end else if (too_big) begin
                        dz_d  = 1'b0;
                        ovf_d = 1'b1;
                        a_d   = '1;
                        r_d   = '0;
                    end else begin
                        dz_d  = 1'b0;
                        ovf_d = 1'b0;
                        rem_d = z_hi;
                        qsh_d = Z[WIDTH-1:0];
                        cnt_d = CNT_W'(WIDTH);
                    end
                end
            end
            StRun: begin
                rem_d = rem_next;
                qsh_d = qsh_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    a_d = qsh_next;
                    r_d = rem_next;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            qsh_q <= '0;
            b_q   <= '0;
            a_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            qsh_q <= qsh_d;
            b_q   <= b_d;
            a_q   <= a_d;
            r_q   <= r_d;
            dz_q  <= dz_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign A        = a_q;
    assign R        = r_q;
    assign div_zero = dz_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Bench for seq_divider_32by16: directed vectors plus a multiply round-trip,
// with a scoreboard queue consumed by an independent output monitor.
module tb_seq_divider_32by16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] z = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] a;
    logic [15:0] r;
    logic        div_zero;
    logic        ovf;

    seq_divider_32by16 #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Z         (z),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (a),
        .R         (r),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] ea;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks latency on the first out_valid cycle, values on handshake.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got A=%0h R=%0h with nothing pending",
                             a, r);
                end else begin
                    chk("latency", 32'(cyc + 1 - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("quotient", 32'(a), 32'(e.ea));
                chk("remainder", 32'(r), 32'(e.er));
                chk("div_zero", 32'(div_zero), 32'(e.edz));
                chk("ovf", 32'(ovf), 32'(e.eov));
            end
            prev_ov = out_valid;
        end
    end

    // Present one operation, wait (bounded) for acceptance, log expectation.
    task automatic issue(input logic [31:0] zi, input logic [15:0] bi,
                         input logic [15:0] ea, input logic [15:0] er,
                         input logic edz, input logic eov, input int lat);
        exp_t e;
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        z = zi;
        b = bi;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        e.ea  = ea;
        e.er  = er;
        e.edz = edz;
        e.eov = eov;
        e.acc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Inputs are scrambled after accept; the result must not change.
        z = $urandom;
        b = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ra, rb, rr;
        logic [31:0] rz;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_A", 32'(a), 32'd0);
        chk("rst_R", 32'(r), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal divisions
        issue(32'h000F4240, 16'd1000, 16'd1000, 16'd0, 1'b0, 1'b0, 17);
        wait_idle();
        issue(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 17);
        issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
        issue(32'h0009FFFF, 16'h000A, 16'hFFFF, 16'd9, 1'b0, 1'b0, 17);
        issue(32'd0, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0, 17);
        wait_idle();

        // Divide by zero and overflow (Z high half equal to B)
        issue(32'h12345678, 16'h0000, 16'hFFFF, 16'd0, 1'b1, 1'b0, 1);
        issue(32'h00100000, 16'h0010, 16'hFFFF, 16'd0, 1'b0, 1'b1, 1);
        wait_idle();

        // Backpressure: result held, new request ignored
        out_ready = 1'b0;
        issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) break;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k == 3);
            z = 32'd999;
            b = 16'd5;
            @(negedge clk);
            #1;
            chk("hold_A", 32'(a), 32'd14);
            chk("hold_R", 32'(r), 32'd2);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of RUN discards the operation
        issue(32'd5000, 16'd7, 16'd714, 16'd2, 1'b0, 1'b0, 17);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_A", 32'(a), 32'd0);
        chk("midrst_R", 32'(r), 32'd0);
        issue(32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 17);
        wait_idle();

        // Round trip through multiplication: Z = a*b + r with r < b
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom_range(0, 65535);
            rb = $urandom_range(1, 65535);
            rr = $urandom_range(0, rb - 1);
            rz = ra * rb + rr;
            issue(rz, rb[15:0], ra[15:0], rr[15:0], 1'b0, 1'b0, 17);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
